// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl
// Time-multiplexed scan of N_VAL signed nibbles onto a shared active-low
// 7-segment bus. Each value gets a sign digit and a magnitude digit. One
// external lookup is shared between all digits through the lk_* ports.
// Values are latched once per frame so a frame never shows a torn mix of
// old and new operands.

module seg_scan_ctrl #(
    parameter int N_VAL        = 3,
    parameter int DWELL        = 4,
    parameter int BLANK        = 1,
    parameter int BLINK_FRAMES = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic [4*N_VAL-1:0]   vals,
    input  logic [N_VAL-1:0]     blink_mask,
    output logic [3:0]           lk_in,
    input  logic [6:0]           lk_l,
    input  logic [6:0]           lk_r,
    output logic [6:0]           seg,
    output logic [2*N_VAL-1:0]   an,
    output logic                 frame_done
);

    localparam int N_DIG = 2 * N_VAL;
    localparam int IW    = $clog2(N_DIG);
    localparam int MAXC  = (DWELL > BLANK) ? DWELL : BLANK;
    localparam int CW    = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam int FW    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [IW-1:0] IDX_LAST   = IW'(N_DIG - 1);
    localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK > 0) ? BLANK - 1 : 0);
    localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_SHOW,
        S_BLANK
    } state_t;

    state_t              state;
    logic [IW-1:0]       idx;
    logic [CW-1:0]       cnt;
    logic [FW-1:0]       frame_cnt;
    logic                blink_on;
    logic [4*N_VAL-1:0]  shadow;

    logic [IW-1:0]       val_sel;
    logic                val_blink;
    logic                frame_end;
    logic [N_DIG-1:0]    an_view;
    logic [6:0]          seg_view;

    // Pick the value behind the current digit: feeds the lookup and the blink select
    always_comb begin
        val_sel   = idx >> 1;
        lk_in     = 4'h0;
        val_blink = 1'b0;
        for (int v = 0; v < N_VAL; v++) begin
            if (val_sel == IW'(v)) begin
                lk_in     = shadow[4*v +: 4];
                val_blink = blink_mask[v];
            end
        end
    end

    // Last cycle of the last digit, including its blank gap when one exists
    always_comb begin
        frame_end = (idx == IDX_LAST) &&
                    (((state == S_SHOW) && (cnt == DWELL_LAST) && (BLANK == 0)) ||
                     ((state == S_BLANK) && (cnt == BLANK_LAST)));
    end

    // What the display should show for the current FSM state, registered next edge
    always_comb begin
        an_view  = '1;
        seg_view = 7'h7F;
        if (state == S_SHOW) begin
            for (int d = 0; d < N_DIG; d++) begin
                if (idx == IW'(d)) begin
                    an_view[d] = 1'b0;
                end
            end
            if (!(val_blink && !blink_on)) begin
                seg_view = idx[0] ? lk_r : lk_l;
            end
        end
    end

    // Scan FSM with dwell/blank timing, blink bookkeeping and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            idx        <= '0;
            cnt        <= '0;
            frame_cnt  <= '0;
            blink_on   <= 1'b1;
            shadow     <= '0;
            seg        <= 7'h7F;
            an         <= '1;
            frame_done <= 1'b0;
        end else begin
            seg        <= seg_view;
            an         <= an_view;
            frame_done <= 1'b0;
            if (!en) begin
                state     <= S_IDLE;
                idx       <= '0;
                cnt       <= '0;
                frame_cnt <= '0;
                blink_on  <= 1'b1;
            end else begin
                case (state)
                    S_IDLE: begin
                        state <= S_LOAD;
                    end
                    S_LOAD: begin
                        shadow <= vals;
                        idx    <= '0;
                        cnt    <= '0;
                        state  <= S_SHOW;
                    end
                    S_SHOW: begin
                        if (cnt == DWELL_LAST) begin
                            cnt <= '0;
                            if (BLANK > 0) begin
                                state <= S_BLANK;
                            end else if (frame_end) begin
                                state <= S_LOAD;
                            end else begin
                                idx <= idx + IW'(1);
                            end
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                    S_BLANK: begin
                        if (cnt == BLANK_LAST) begin
                            cnt <= '0;
                            if (frame_end) begin
                                state <= S_LOAD;
                            end else begin
                                idx   <= idx + IW'(1);
                                state <= S_SHOW;
                            end
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
                if (frame_end) begin
                    frame_done <= 1'b1;
                    if (frame_cnt == FRAME_LAST) begin
                        frame_cnt <= '0;
                        blink_on  <= ~blink_on;
                    end else begin
                        frame_cnt <= frame_cnt + FW'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl
// Two scan controllers share one stimulus stream: one with a blank gap and a
// short blink period, one with single-cycle back-to-back digits. Each has a
// frame-position model that predicts every lit digit and every frame_done
// pulse into queues; a monitor on the falling edge pops and compares them.

module tb_seg_scan_ctrl;

    localparam int N_VAL = 3;
    localparam int N_DIG = 2 * N_VAL;

    typedef struct {
        int               cyc;
        logic [N_DIG-1:0] an;
        logic [6:0]       seg;
    } exp_t;

    logic                 clk;
    logic                 rst_n;
    logic                 en;
    logic [4*N_VAL-1:0]   vals;
    logic [N_VAL-1:0]     blink_mask;

    logic [1:0][3:0]       lk_in_o;
    logic [1:0][6:0]       lk_l_o;
    logic [1:0][6:0]       lk_r_o;
    logic [1:0][6:0]       seg_o;
    logic [1:0][N_DIG-1:0] an_o;
    logic [1:0]            fd_o;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    // Signed nibble to {sign pattern, magnitude pattern}, active-low gfedcba
    function automatic logic [13:0] lookup7(input logic [3:0] n);
        logic [6:0] sgn;
        logic [6:0] mag_pat;
        int         mag;
        mag = n[3] ? 16 - int'(n) : int'(n);
        sgn = n[3] ? 7'b0111111 : 7'b1111111;
        case (mag)
            0:       mag_pat = 7'b1000000;
            1:       mag_pat = 7'b1111001;
            2:       mag_pat = 7'b0100100;
            3:       mag_pat = 7'b0110000;
            4:       mag_pat = 7'b0011001;
            5:       mag_pat = 7'b0010010;
            6:       mag_pat = 7'b0000010;
            7:       mag_pat = 7'b1111000;
            default: mag_pat = 7'b0000000;
        endcase
        return {sgn, mag_pat};
    endfunction

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Cycle stamp shared by the models and monitors
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 2; g++) begin : cfg
        localparam int DW   = (g == 0) ? 4 : 1;
        localparam int BL   = (g == 0) ? 1 : 0;
        localparam int BF   = (g == 0) ? 2 : 1;
        localparam int SLOT = DW + BL;
        localparam int FLEN = N_DIG * SLOT + 1;

        exp_t        exp_q[$];
        int          fd_q[$];
        int          pos = -1;
        int          frames = 0;
        int          prev_pos;
        int          q;
        int          d;
        int          fd_pop;
        logic [11:0] shadow_m = '0;
        logic [13:0] tbl;
        exp_t        e_push;
        exp_t        e_pop;

        seg_scan_ctrl #(
            .N_VAL(N_VAL),
            .DWELL(DW),
            .BLANK(BL),
            .BLINK_FRAMES(BF)
        ) dut (
            .clk(clk),
            .rst_n(rst_n),
            .en(en),
            .vals(vals),
            .blink_mask(blink_mask),
            .lk_in(lk_in_o[g]),
            .lk_l(lk_l_o[g]),
            .lk_r(lk_r_o[g]),
            .seg(seg_o[g]),
            .an(an_o[g]),
            .frame_done(fd_o[g])
        );

        assign {lk_l_o[g], lk_r_o[g]} = lookup7(lk_in_o[g]);

        // Reference model: position within a frame (0 = load slot), digits by division
        initial forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                pos    = -1;
                frames = 0;
                exp_q.delete();
                fd_q.delete();
            end else begin
                prev_pos = pos;
                if (prev_pos >= 1) begin
                    q = prev_pos - 1;
                    d = q / SLOT;
                    if ((q % SLOT) < DW) begin
                        tbl          = lookup7(shadow_m[4*(d/2) +: 4]);
                        e_push.cyc   = cyc + 1;
                        e_push.an    = '1;
                        e_push.an[d] = 1'b0;
                        e_push.seg   = (d % 2 == 1) ? tbl[6:0] : tbl[13:7];
                        if (blink_mask[d/2] && ((frames / BF) % 2 == 1)) begin
                            e_push.seg = 7'h7F;
                        end
                        exp_q.push_back(e_push);
                    end
                end
                if (!en) begin
                    pos    = -1;
                    frames = 0;
                end else if (pos < 0) begin
                    pos = 0;
                end else begin
                    if (pos == 0) shadow_m = vals;
                    pos = pos + 1;
                    if (pos == FLEN) begin
                        pos    = 0;
                        frames = frames + 1;
                        fd_q.push_back(cyc + 1);
                    end
                end
            end
        end

        // Monitor: compare lit digits and frame_done pulses against the queues
        initial forever begin
            @(negedge clk);
            if (rst_n) begin
                checks++;
                if ($countones(~an_o[g]) > 1) begin
                    errors++;
                    $display("[TB] FAIL cfg%0d onehot: an=%b at cyc %0d, want at most one low bit", g, an_o[g], cyc);
                end
                while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                    checks++;
                    errors++;
                    e_pop = exp_q.pop_front();
                    $display("[TB] FAIL cfg%0d missing_digit: nothing lit at cyc %0d, want an=%b seg=%b", g, e_pop.cyc, e_pop.an, e_pop.seg);
                end
                checks++;
                if (an_o[g] == '1) begin
                    if (seg_o[g] != 7'h7F) begin
                        errors++;
                        $display("[TB] FAIL cfg%0d blank_seg: seg=%b at cyc %0d, want 1111111", g, seg_o[g], cyc);
                    end
                end else if (exp_q.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL cfg%0d unexpected_digit: an=%b seg=%b at cyc %0d, want all off", g, an_o[g], seg_o[g], cyc);
                end else begin
                    e_pop = exp_q.pop_front();
                    if (e_pop.cyc != cyc || e_pop.an != an_o[g] || e_pop.seg != seg_o[g]) begin
                        errors++;
                        $display("[TB] FAIL cfg%0d digit: got cyc=%0d an=%b seg=%b, want cyc=%0d an=%b seg=%b", g, cyc, an_o[g], seg_o[g], e_pop.cyc, e_pop.an, e_pop.seg);
                    end
                end
                while (fd_q.size() > 0 && fd_q[0] < cyc) begin
                    checks++;
                    errors++;
                    fd_pop = fd_q.pop_front();
                    $display("[TB] FAIL cfg%0d missing_frame_done: no pulse at cyc %0d", g, fd_pop);
                end
                if (fd_o[g]) begin
                    checks++;
                    if (fd_q.size() == 0) begin
                        errors++;
                        $display("[TB] FAIL cfg%0d unexpected_frame_done: pulse at cyc %0d, want none", g, cyc);
                    end else begin
                        fd_pop = fd_q.pop_front();
                        if (fd_pop != cyc) begin
                            errors++;
                            $display("[TB] FAIL cfg%0d frame_done: pulse at cyc %0d, want cyc %0d", g, cyc, fd_pop);
                        end
                    end
                end
            end
        end
    end

    // Drive inputs and hold them for n rising edges (caller sits just after an edge)
    task automatic applyStimulus(input logic e, input logic [11:0] v, input logic [2:0] m, input int n);
        en         = e;
        vals       = v;
        blink_mask = m;
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    // Direct comparison of one controller's outputs against fixed values
    task automatic checkOutput(input string name, input int g, input logic [N_DIG-1:0] want_an,
                               input logic [6:0] want_seg, input logic want_fd);
        checks++;
        if (an_o[g] != want_an || seg_o[g] != want_seg || fd_o[g] != want_fd) begin
            errors++;
            $display("[TB] FAIL %s cfg%0d: got an=%b seg=%b fd=%b, want an=%b seg=%b fd=%b", name, g, an_o[g], seg_o[g], fd_o[g], want_an, want_seg, want_fd);
        end
    endtask

    // Wait (bounded) until controller 0 lights a given digit
    task automatic waitDigit(input logic [N_DIG-1:0] want);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < 100 && !hit; i++) begin
            @(posedge clk);
            #2;
            if (an_o[0] == want) hit = 1'b1;
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("[TB] FAIL wait_digit: an never became %b, last an=%b", want, an_o[0]);
        end
    endtask

    // Distance between two consecutive frame_done pulses of one controller
    task automatic measurePeriod(input int g, input int want);
        int t0;
        int got;
        t0  = -1;
        got = -1;
        for (int i = 0; i < 200 && got < 0; i++) begin
            @(negedge clk);
            if (fd_o[g]) begin
                if (t0 < 0) t0 = cyc;
                else got = cyc - t0;
            end
        end
        checks++;
        if (got != want) begin
            errors++;
            $display("[TB] FAIL frame_period cfg%0d: got %0d cycles, want %0d", g, got, want);
        end
        @(posedge clk);
        #2;
    endtask

    // Safety net so the run always ends
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed scenarios followed by randomized traffic
    initial begin
        logic        e_r;
        logic [11:0] v_r;
        logic [2:0]  m_r;
        rst_n      = 1'b0;
        en         = 1'b0;
        vals       = '0;
        blink_mask = '0;
        repeat (3) @(posedge clk);
        #2;
        checkOutput("reset", 0, '1, 7'h7F, 1'b0);
        checkOutput("reset", 1, '1, 7'h7F, 1'b0);
        rst_n = 1'b1;
        applyStimulus(1'b0, 12'h7D3, 3'b000, 4);
        checkOutput("idle_hold", 0, '1, 7'h7F, 1'b0);

        $display("[TB] basic scan of 7, -3, 3");
        applyStimulus(1'b1, 12'h7D3, 3'b000, 2);
        measurePeriod(0, 31);
        measurePeriod(1, 7);
        applyStimulus(1'b1, 12'h7D3, 3'b000, 40);

        $display("[TB] values change during the v0 digits");
        waitDigit(6'b111110);
        applyStimulus(1'b1, 12'h8A5, 3'b000, 80);

        $display("[TB] enable dropped during v1");
        waitDigit(6'b111011);
        applyStimulus(1'b0, 12'h8A5, 3'b000, 3);
        applyStimulus(1'b1, 12'h8A5, 3'b000, 70);

        $display("[TB] blink on v1");
        applyStimulus(1'b0, 12'h7D3, 3'b010, 2);
        applyStimulus(1'b1, 12'h7D3, 3'b010, 140);

        $display("[TB] randomized traffic");
        v_r = 12'h7D3;
        m_r = 3'b000;
        for (int i = 0; i < 250; i++) begin
            e_r = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 2) == 0) v_r = 12'($urandom);
            if ($urandom_range(0, 3) == 0) m_r = 3'($urandom);
            applyStimulus(e_r, v_r, m_r, $urandom_range(1, 15));
        end

        $display("[TB] reset during a lit digit");
        applyStimulus(1'b1, 12'h4E1, 3'b000, 10);
        waitDigit(6'b110111);
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset", 0, '1, 7'h7F, 1'b0);
        checkOutput("async_reset", 1, '1, 7'h7F, 1'b0);
        #1;
        repeat (2) begin
            @(posedge clk);
            #2;
        end
        en    = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #2;
            checkOutput("idle_after_reset", 0, '1, 7'h7F, 1'b0);
        end
        applyStimulus(1'b1, 12'h2F6, 3'b101, 80);
        applyStimulus(1'b0, 12'h2F6, 3'b101, 8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
